// File: rtl/sram_controller.sv
// MEM-stage bridge from a 32-bit CPU load/store port to a 16-bit async SRAM.
// Each access is two halfword cycles of WAIT_CYCLES each (low half, then high
// half), followed by a one-cycle DONE.
//
// Ports:
//   clock, rst        rising-edge clock, async active-high reset
//   rd_en, wr_en      load/store request, held until ready
//   address           CPU byte address; ADDR_BASE maps to halfword 0
//   write_data        store data
//   read_data         load result, held until the next load
//   ready             access complete or idle (pipeline freeze = ~ready)
//   sram_addr         SRAM halfword address
//   sram_dq_out/_oe   write data and bus drive enable
//   sram_dq_in        read data from SRAM
//   sram_*_n          active-low SRAM strobes
module sram_controller #(
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [31:0] BASE = 32'(ADDR_BASE);
  localparam logic [3:0]  LAST = 4'(WAIT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_wr_q, op_wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        cnt_last;

  // SRAM pins are registered so the strobes are glitch-free; they are
  // computed from next-state so they line up with the state they belong to.
  logic [17:0] saddr_q, saddr_d;
  logic [15:0] dqo_q, dqo_d;
  logic        dqoe_q, dqoe_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        bs_n_q, bs_n_d;

  logic        act_d;
  logic        high_d;
  logic [31:0] word_d;
  logic        unused_word;

  assign cnt_last = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // A store wins when both requests are raised together.
        if (wr_en) begin
          addr_d  = address;
          wdata_d = write_data;
          op_wr_d = 1'b1;
          state_d = S_LOW;
        end else if (rd_en) begin
          addr_d  = address;
          op_wr_d = 1'b0;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = S_HIGH;
          if (!op_wr_q) rdata_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HIGH: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = S_DONE;
          if (!op_wr_q) rdata_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Halfword index wraps modulo 2^32; out-of-window bits are simply dropped.
  assign word_d      = addr_d - BASE;
  assign unused_word = ^{word_d[31:19], word_d[1:0]};

  assign act_d  = (state_d == S_LOW) || (state_d == S_HIGH);
  assign high_d = (state_d == S_HIGH);

  always_comb begin
    saddr_d = '0;
    dqo_d   = '0;
    dqoe_d  = 1'b0;
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    bs_n_d  = 1'b1;
    unique case (1'b1)
      act_d && op_wr_d: begin
        saddr_d = {word_d[18:2], high_d};
        dqo_d   = high_d ? wdata_d[31:16] : wdata_d[15:0];
        dqoe_d  = 1'b1;
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        bs_n_d  = 1'b0;
      end
      act_d && !op_wr_d: begin
        saddr_d = {word_d[18:2], high_d};
        ce_n_d  = 1'b0;
        oe_n_d  = 1'b0;
        bs_n_d  = 1'b0;
      end
      default: begin
        saddr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      saddr_q <= '0;
      dqo_q   <= '0;
      dqoe_q  <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      bs_n_q  <= 1'b1;
    end else begin
      saddr_q <= saddr_d;
      dqo_q   <= dqo_d;
      dqoe_q  <= dqoe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      bs_n_q  <= bs_n_d;
    end
  end

  // A request seen in IDLE freezes the pipe in the same cycle.
  assign ready = ((state_q == S_IDLE) && !rd_en && !wr_en)
              || (state_q == S_DONE);

  assign read_data   = rdata_q;
  assign sram_addr   = saddr_q;
  assign sram_dq_out = dqo_q;
  assign sram_dq_oe  = dqoe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_ub_n   = bs_n_q;
  assign sram_lb_n   = bs_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: WAIT_CYCLES=2 instance with a small
// SRAM model, plus a WAIT_CYCLES=1 instance for the short-latency case.
module tb_sram_controller;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic        rd_en1 = 1'b0, wr_en1 = 1'b0;
  logic [31:0] address = '0, write_data = '0;

  logic [31:0] read_data, read_data1;
  logic        ready, ready1;
  logic [17:0] sram_addr, sram_addr1;
  logic [15:0] sram_dq_out, sram_dq_out1;
  logic        sram_dq_oe, sram_dq_oe1;
  logic [15:0] sram_dq_in;
  logic [15:0] sram_dq_in1 = 16'h0;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic        ce_n1, oe_n1, we_n1, ub_n1, lb_n1;

  int n_err = 0;
  int n_chk = 0;

  logic [15:0] mem [16];

  always #5 clock = ~clock;

  sram_controller #(.ADDR_BASE(1024), .WAIT_CYCLES(2)) dut (
    .clock(clock), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n)
  );

  sram_controller #(.ADDR_BASE(1024), .WAIT_CYCLES(1)) dut1 (
    .clock(clock), .rst(rst), .rd_en(rd_en1), .wr_en(wr_en1),
    .address(address), .write_data(write_data),
    .read_data(read_data1), .ready(ready1),
    .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1),
    .sram_dq_oe(sram_dq_oe1), .sram_dq_in(sram_dq_in1),
    .sram_ce_n(ce_n1), .sram_oe_n(oe_n1),
    .sram_we_n(we_n1), .sram_ub_n(ub_n1),
    .sram_lb_n(lb_n1)
  );

  always @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'h0;
    end else if (!sram_ce_n && !sram_we_n) begin
      mem[sram_addr[3:0]] <= sram_dq_out;
    end
  end

  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[3:0]] : 16'h0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #2;
  endtask

  initial begin
    #1 rst = 1'b1;
    nxt();
    nxt();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_ce_n", 32'(sram_ce_n), 32'd1);
    check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_rdata", read_data, 32'd0);
    check("rst_ready1", 32'(ready1), 32'd1);
    rst = 1'b0;

    // Write 0xDEADBEEF to 1028
    nxt();
    wr_en = 1'b1; address = 32'd1028; write_data = 32'hDEADBEEF;
    #1 check("wr_c0_ready", 32'(ready), 32'd0);
    for (int c = 1; c <= 5; c++) begin
      nxt();
      check($sformatf("wr_c%0d_ready", c), 32'(ready), 32'(c == 5));
      if (c <= 4) begin
        check($sformatf("wr_c%0d_addr", c), 32'(sram_addr), (c <= 2) ? 32'd2 : 32'd3);
        check($sformatf("wr_c%0d_dq", c), 32'(sram_dq_out),
              (c <= 2) ? 32'h0000BEEF : 32'h0000DEAD);
        check($sformatf("wr_c%0d_we_n", c), 32'(sram_we_n), 32'd0);
        check($sformatf("wr_c%0d_oe_n", c), 32'(sram_oe_n), 32'd1);
        check($sformatf("wr_c%0d_dq_oe", c), 32'(sram_dq_oe), 32'd1);
        check($sformatf("wr_c%0d_ce_n", c), 32'(sram_ce_n), 32'd0);
      end else begin
        check("wr_done_ce_n", 32'(sram_ce_n), 32'd1);
        check("wr_done_addr", 32'(sram_addr), 32'd0);
        check("wr_done_dq", 32'(sram_dq_out), 32'd0);
        wr_en = 1'b0;
      end
    end
    check("wr_rdata_kept", read_data, 32'd0);

    // Read back from 1028
    nxt();
    rd_en = 1'b1; address = 32'd1028; write_data = 32'h0;
    #1 check("rd_c0_ready", 32'(ready), 32'd0);
    for (int c = 1; c <= 5; c++) begin
      nxt();
      check($sformatf("rd_c%0d_ready", c), 32'(ready), 32'(c == 5));
      if (c <= 4) begin
        check($sformatf("rd_c%0d_oe_n", c), 32'(sram_oe_n), 32'd0);
        check($sformatf("rd_c%0d_we_n", c), 32'(sram_we_n), 32'd1);
        check($sformatf("rd_c%0d_dq_oe", c), 32'(sram_dq_oe), 32'd0);
        check($sformatf("rd_c%0d_addr", c), 32'(sram_addr), (c <= 2) ? 32'd2 : 32'd3);
      end else begin
        check("rd_data", read_data, 32'hDEADBEEF);
        rd_en = 1'b0;
      end
    end

    // Simultaneous rd/wr performs the write only
    nxt();
    rd_en = 1'b1; wr_en = 1'b1;
    address = 32'd1024; write_data = 32'h12345678;
    for (int c = 1; c <= 5; c++) begin
      nxt();
      if (c == 1) begin
        check("both_we_n", 32'(sram_we_n), 32'd0);
        check("both_oe_n", 32'(sram_oe_n), 32'd1);
        check("both_addr", 32'(sram_addr), 32'd0);
        check("both_dq", 32'(sram_dq_out), 32'h00005678);
      end
      if (c == 3) check("both_dq_hi", 32'(sram_dq_out), 32'h00001234);
      if (c == 5) begin
        check("both_ready", 32'(ready), 32'd1);
        check("both_rdata", read_data, 32'hDEADBEEF);
        rd_en = 1'b0; wr_en = 1'b0;
      end
    end

    // Back-to-back writes with wr_en held; inputs change mid-access
    nxt();
    wr_en = 1'b1; address = 32'd1028; write_data = 32'hCAFEF00D;
    for (int c = 1; c <= 11; c++) begin
      nxt();
      if (c == 2) begin
        address = 32'd1032; write_data = 32'h0BADC0DE;
      end
      check($sformatf("b2b_c%0d_ready", c), 32'(ready), 32'(c == 5 || c == 11));
      check($sformatf("b2b_c%0d_ce_n", c), 32'(sram_ce_n),
            32'(c == 5 || c == 6 || c == 11));
      if (c == 3) check("b2b_hold_addr", 32'(sram_addr), 32'd3);
      if (c == 4) check("b2b_hold_dq", 32'(sram_dq_out), 32'h0000CAFE);
      if (c == 7) begin
        check("b2b_2nd_addr", 32'(sram_addr), 32'd4);
        check("b2b_2nd_dq", 32'(sram_dq_out), 32'h0000C0DE);
      end
      if (c == 11) wr_en = 1'b0;
    end

    // Below-base address wraps; WAIT_CYCLES=1 instance finishes at cycle 3
    nxt();
    wr_en = 1'b1; wr_en1 = 1'b1;
    address = 32'd1020; write_data = 32'h55AA33CC;
    #1 check("bnd1_c0_ready", 32'(ready1), 32'd0);
    for (int c = 1; c <= 5; c++) begin
      nxt();
      if (c <= 3) check($sformatf("bnd1_c%0d_ready", c), 32'(ready1), 32'(c == 3));
      if (c == 1) begin
        check("bnd_lo_addr", 32'(sram_addr), 32'h3FFFE);
        check("bnd1_lo_addr", 32'(sram_addr1), 32'h3FFFE);
      end
      if (c == 2) check("bnd1_hi_addr", 32'(sram_addr1), 32'h3FFFF);
      if (c == 3) begin
        check("bnd_hi_addr", 32'(sram_addr), 32'h3FFFF);
        wr_en1 = 1'b0;
      end
      if (c == 5) begin
        check("bnd_ready", 32'(ready), 32'd1);
        wr_en = 1'b0;
      end
    end

    // Reset in the middle of a write
    nxt();
    wr_en = 1'b1; address = 32'd1028; write_data = 32'h11112222;
    nxt(); nxt(); nxt();
    check("mid_active_ce_n", 32'(sram_ce_n), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_ce_n", 32'(sram_ce_n), 32'd1);
    check("mid_rst_we_n", 32'(sram_we_n), 32'd1);
    check("mid_rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("mid_rst_addr", 32'(sram_addr), 32'd0);
    check("mid_rst_dq", 32'(sram_dq_out), 32'd0);
    check("mid_rst_rdata", read_data, 32'd0);
    check("mid_rst_ready_req", 32'(ready), 32'd0);
    wr_en = 1'b0;
    #1 check("mid_rst_ready", 32'(ready), 32'd1);
    nxt();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      nxt();
      check($sformatf("post_c%0d_ready", c), 32'(ready), 32'd1);
      check($sformatf("post_c%0d_ce_n", c), 32'(sram_ce_n), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 1024: CPU byte address that maps to SRAM halfword 0.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, legal range 1-15: clock cycles per 16-bit SRAM access.
REQ-003 SHALL have port clock, input, 1: clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port rd_en, input, 1: MEM-stage load request, held until ready=1.
REQ-006 SHALL have port wr_en, input, 1: MEM-stage store request, held until ready=1.
REQ-007 SHALL have port address, input, 32: CPU byte address (ALU result).
REQ-008 SHALL have port write_data, input, 32: store data (Rm value).
REQ-009 SHALL have port read_data, output, 32: load result.
REQ-010 SHALL have port ready, output, 1: access complete or idle; pipeline freeze = ~ready.
REQ-011 SHALL have port sram_addr, output, 18: SRAM halfword address.
REQ-012 SHALL have port sram_dq_out, output, 16: write data to SRAM.
REQ-013 SHALL have port sram_dq_oe, output, 1: 1 = controller drives the DQ bus.
REQ-014 SHALL have port sram_dq_in, input, 16: read data from SRAM.
REQ-015 SHALL have ports sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, output, 1 each: active-low SRAM strobes.

Function
REQ-016 SHALL implement an FSM with states IDLE, LOW, HIGH, DONE.
REQ-017 In IDLE with wr_en=1, SHALL latch address and write_data, set op=write, and go to LOW; in IDLE with rd_en=1 and wr_en=0, SHALL latch address, set op=read, and go to LOW; otherwise SHALL stay in IDLE.
REQ-018 If rd_en and wr_en are both 1, SHALL perform the write only.
REQ-019 SHALL compute word = (latched address - ADDR_BASE) mod 2^32; sram_addr = {word[18:2], 0} in LOW and {word[18:2], 1} in HIGH; address bits [1:0] and [31:19] of word SHALL be ignored, with no range check.
REQ-020 SHALL hold each of LOW and HIGH for exactly WAIT_CYCLES cycles using a 4-bit counter that is cleared on each state entry.
REQ-021 SHALL go LOW->HIGH and HIGH->DONE on the last counted cycle, and DONE->IDLE unconditionally after 1 cycle.
REQ-022 During LOW/HIGH: sram_ce_n=0, sram_ub_n=0, sram_lb_n=0; for a read, sram_oe_n=0, sram_we_n=1, sram_dq_oe=0; for a write, sram_oe_n=1, sram_we_n=0, sram_dq_oe=1.
REQ-023 For a write, sram_dq_out SHALL be write_data[15:0] in LOW and write_data[31:16] in HIGH.
REQ-024 In IDLE/DONE: all strobes SHALL be 1, sram_dq_oe=0, sram_dq_out=0, sram_addr=0.
REQ-025 For a read, read_data[15:0] SHALL capture sram_dq_in on the last LOW cycle and read_data[31:16] on the last HIGH cycle; read_data SHALL hold its value until the next read overwrites it, and writes SHALL NOT change it.
REQ-026 ready SHALL equal (state==IDLE and rd_en=0 and wr_en=0) or state==DONE (combinational).
REQ-027 Latency: with the request sampled in IDLE at cycle 0, ready SHALL be 1 at cycle 2*WAIT_CYCLES+1 and 0 in cycles 0..2*WAIT_CYCLES.
REQ-028 A request still asserted during DONE SHALL NOT start a new access; a new access starts only from IDLE, so back-to-back requests cost 2*WAIT_CYCLES+2 cycles each.
REQ-029 Changes to address, write_data, rd_en, or wr_en after acceptance SHALL NOT affect the access in progress.

Reset
REQ-030 On rst=1 at any time, including mid-access, the block SHALL asynchronously force: state=IDLE, counter=0, read_data=0, latched address/data=0, all strobes=1, sram_dq_oe=0, sram_dq_out=0, sram_addr=0.
REQ-031 On rst=1, ready SHALL follow REQ-026 (1 if no request is pending).
REQ-032 An aborted access SHALL NOT be resumed after rst is released.

Verification
REQ-033 Write, WAIT_CYCLES=2: wr_en=1, address=1028, write_data=0xDEADBEEF -> cycles 1-2: sram_addr=2, dq_out=0xBEEF, we_n=0; cycles 3-4: sram_addr=3, dq_out=0xDEAD; ready=1 at cycle 5 only.
REQ-034 Read back: rd_en=1, address=1028, SRAM model holding 0xBEEF/0xDEAD -> read_data=0xDEADBEEF with ready=1 at cycle 5; oe_n=0 and dq_oe=0 throughout the access.
REQ-035 Simultaneous request: rd_en=wr_en=1, address=1024, write_data=0x12345678 -> write performed (we_n=0), read_data unchanged.
REQ-036 Reset mid-access: rst pulse at cycle 3 of a write -> same timestep: all strobes=1, dq_oe=0, state IDLE; after release with no request: ready=1, no further SRAM activity.
REQ-037 Boundary: address=1020 (below base) -> word=0xFFFFFFFC, sram_addr=0x3FFFE then 0x3FFFF; WAIT_CYCLES=1 run -> ready at cycle 3.
REQ-038 Back-to-back: two writes with rd_en/wr_en held continuously -> second access starts at cycle 7 (WAIT_CYCLES=2), with no overlap of strobes.
